// File: rtl/pe_ipad_ring_pkg.sv
// pe_ipad_ring_pkg
// Shared definitions for the input-pixel ring scratchpad: default geometry
// and the controller state encoding.
package pe_ipad_ring_pkg;

   localparam int IRING_DWD_DEF   = 16;
   localparam int IRING_DEPTH_DEF = 12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } IRingState;

endpackage

// File: rtl/pe_ipad_ring_mem.sv
// pe_ipad_ring_mem
// Depth x (DWd+1) flop array backing the ring. Bit DWd of each entry is the
// zero flag captured with the pixel. Contents are never reset.
// Ports:
//   i_clk             clock
//   i_we              write enable
//   i_waddr, i_wdata  write port (flag in MSB)
//   i_raddr, o_rdata  combinational read port
module pe_ipad_ring_mem #(
   parameter int DWd   = 16,
   parameter int Depth = 12,
   parameter int PW    = 4
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [PW-1:0] i_waddr,
   input  logic [DWd:0]  i_wdata,
   input  logic [PW-1:0] i_raddr,
   output logic [DWd:0]  o_rdata
);

   logic [DWd:0] mem_r [Depth];

   // Single write port into the entry array
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         mem_r[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = mem_r[i_raddr];

endmodule

// File: rtl/pe_ipad_ring.sv
// pe_ipad_ring
// Circular input-pixel scratchpad. Accepts a pixel stream and replays sliding
// windows (length win, advance stride, nwin windows, reps passes each). A read
// may start as soon as the addressed entry has been written.
// Ports:
//   i_clk, i_rstn (sync, active-low), i_clear (sync soft reset), i_stall
//   i_start + i_conf_{win,stride,nwin,reps}: job configuration
//   i_wvalid/o_wready/i_wdata: pixel write stream
//   o_rvalid/i_rready/o_rdata, o_rzero, o_rlast: window read stream
//   o_busy (RUN), o_done (DONE), o_cfg_err (rejected start pulse)
module pe_ipad_ring
   import pe_ipad_ring_pkg::*;
#(
   parameter int DWd    = IRING_DWD_DEF,
   parameter int Depth  = IRING_DEPTH_DEF,
   parameter int NWinWd = 10,
   parameter int RepWd  = 4
) (
   input  logic                       i_clk,
   input  logic                       i_rstn,
   input  logic                       i_clear,
   input  logic                       i_stall,
   input  logic                       i_start,
   input  logic [$clog2(Depth+1)-1:0] i_conf_win,
   input  logic [$clog2(Depth+1)-1:0] i_conf_stride,
   input  logic [NWinWd-1:0]          i_conf_nwin,
   input  logic [RepWd-1:0]           i_conf_reps,
   input  logic                       i_wvalid,
   output logic                       o_wready,
   input  logic [DWd-1:0]             i_wdata,
   output logic                       o_rvalid,
   input  logic                       i_rready,
   output logic [DWd-1:0]             o_rdata,
   output logic                       o_rzero,
   output logic                       o_rlast,
   output logic                       o_busy,
   output logic                       o_done,
   output logic                       o_cfg_err
);

   localparam int AW = $clog2(Depth+1);  // counts 0..Depth
   localparam int PW = $clog2(Depth);    // entry index 0..Depth-1
   localparam int TW = NWinWd + AW;      // total writes per job
   localparam logic [AW-1:0] DEPTH_A = AW'(Depth);
   localparam logic [AW:0]   DEPTH_S = (AW+1)'(Depth);

   // Modulo-Depth add by compare-subtract; a < Depth and b <= Depth keep one subtract enough
   function automatic logic [PW-1:0] mod_add(input logic [PW-1:0] a, input logic [AW-1:0] b);
      logic [AW:0] sum;
      sum = (AW+1)'(a) + (AW+1)'(b);
      if (sum >= DEPTH_S) begin
         sum = sum - DEPTH_S;
      end else begin
         sum = sum;
      end
      return PW'(sum);
   endfunction

   IRingState         state_r,   state_n;
   logic [AW-1:0]     win_r,     win_n;
   logic [AW-1:0]     stride_r,  stride_n;
   logic [NWinWd-1:0] nwin_r,    nwin_n;
   logic [RepWd-1:0]  reps_r,    reps_n;
   logic [TW-1:0]     limit_r,   limit_n;
   logic [PW-1:0]     wptr_r,    wptr_n;
   logic [PW-1:0]     base_r,    base_n;
   logic [AW-1:0]     count_r,   count_n;
   logic [AW-1:0]     k_r,       k_n;
   logic [RepWd-1:0]  rep_r,     rep_n;
   logic [NWinWd-1:0] win_idx_r, win_idx_n;
   logic [TW-1:0]     wtotal_r,  wtotal_n;
   logic              cfg_err_r, cfg_err_n;

   logic          cfg_ok_s, wready_s, rvalid_s, wfire_s, rfire_s;
   logic          win_end_s, rep_end_s, pop_s;
   logic [DWd:0]  mem_rd_s;

   assign cfg_ok_s = (i_conf_win != {AW{1'b0}}) && (i_conf_win <= DEPTH_A) &&
                     (i_conf_stride != {AW{1'b0}}) && (i_conf_stride <= i_conf_win) &&
                     (i_conf_nwin != {NWinWd{1'b0}}) && (i_conf_reps != {RepWd{1'b0}});

   // Writes stop once the ring is full or the job's (nwin-1)*stride+win pixels are in
   assign wready_s  = (state_r == RUN) && !i_stall && (count_r < DEPTH_A) && (wtotal_r < limit_r);
   assign rvalid_s  = (state_r == RUN) && !i_stall && (k_r < count_r);
   assign wfire_s   = wready_s && i_wvalid;
   assign rfire_s   = rvalid_s && i_rready;
   assign win_end_s = (k_r == win_r - AW'(1));
   assign rep_end_s = (rep_r == reps_r - RepWd'(1));
   assign pop_s     = rfire_s && win_end_s && rep_end_s;

   pe_ipad_ring_mem #(.DWd(DWd), .Depth(Depth), .PW(PW)) u_mem (
      .i_clk   (i_clk),
      .i_we    (wfire_s),
      .i_waddr (wptr_r),
      .i_wdata ({(i_wdata == {DWd{1'b0}}), i_wdata}),
      .i_raddr (mod_add(base_r, k_r)),
      .o_rdata (mem_rd_s)
   );

   // Next-state and counter updates; stall leaves everything at its current value
   always_comb begin
      state_n   = state_r;
      win_n     = win_r;
      stride_n  = stride_r;
      nwin_n    = nwin_r;
      reps_n    = reps_r;
      limit_n   = limit_r;
      wptr_n    = wptr_r;
      base_n    = base_r;
      count_n   = count_r;
      k_n       = k_r;
      rep_n     = rep_r;
      win_idx_n = win_idx_r;
      wtotal_n  = wtotal_r;
      cfg_err_n = 1'b0;
      if (i_stall) begin
         cfg_err_n = 1'b0;
      end else begin
         case (state_r)
            IDLE, DONE: begin
               if (i_start && cfg_ok_s) begin
                  state_n   = RUN;
                  win_n     = i_conf_win;
                  stride_n  = i_conf_stride;
                  nwin_n    = i_conf_nwin;
                  reps_n    = i_conf_reps;
                  limit_n   = TW'(i_conf_nwin - NWinWd'(1)) * TW'(i_conf_stride) + TW'(i_conf_win);
                  wptr_n    = {PW{1'b0}};
                  base_n    = {PW{1'b0}};
                  count_n   = {AW{1'b0}};
                  k_n       = {AW{1'b0}};
                  rep_n     = {RepWd{1'b0}};
                  win_idx_n = {NWinWd{1'b0}};
                  wtotal_n  = {TW{1'b0}};
               end else if (i_start) begin
                  cfg_err_n = 1'b1;
               end else begin
                  state_n = state_r;
               end
            end
            RUN: begin
               if (wfire_s) begin
                  wptr_n   = mod_add(wptr_r, AW'(1));
                  wtotal_n = wtotal_r + TW'(1);
               end else begin
                  wptr_n   = wptr_r;
               end
               // A completed window releases stride entries even on the final one
               count_n = count_r + AW'(wfire_s) - (pop_s ? stride_r : {AW{1'b0}});
               if (rfire_s && win_end_s) begin
                  k_n = {AW{1'b0}};
                  if (rep_end_s) begin
                     rep_n     = {RepWd{1'b0}};
                     base_n    = mod_add(base_r, stride_r);
                     win_idx_n = win_idx_r + NWinWd'(1);
                     if (win_idx_r == nwin_r - NWinWd'(1)) begin
                        state_n = DONE;
                     end else begin
                        state_n = RUN;
                     end
                  end else begin
                     rep_n = rep_r + RepWd'(1);
                  end
               end else if (rfire_s) begin
                  k_n = k_r + AW'(1);
               end else begin
                  k_n = k_r;
               end
            end
            default: begin
               state_n = IDLE;
            end
         endcase
      end
   end

   // Control registers; reset and soft clear dominate stall and start
   always_ff @(posedge i_clk) begin
      if (!i_rstn || i_clear) begin
         state_r   <= IDLE;
         win_r     <= {AW{1'b0}};
         stride_r  <= {AW{1'b0}};
         nwin_r    <= {NWinWd{1'b0}};
         reps_r    <= {RepWd{1'b0}};
         limit_r   <= {TW{1'b0}};
         wptr_r    <= {PW{1'b0}};
         base_r    <= {PW{1'b0}};
         count_r   <= {AW{1'b0}};
         k_r       <= {AW{1'b0}};
         rep_r     <= {RepWd{1'b0}};
         win_idx_r <= {NWinWd{1'b0}};
         wtotal_r  <= {TW{1'b0}};
         cfg_err_r <= 1'b0;
      end else begin
         state_r   <= state_n;
         win_r     <= win_n;
         stride_r  <= stride_n;
         nwin_r    <= nwin_n;
         reps_r    <= reps_n;
         limit_r   <= limit_n;
         wptr_r    <= wptr_n;
         base_r    <= base_n;
         count_r   <= count_n;
         k_r       <= k_n;
         rep_r     <= rep_n;
         win_idx_r <= win_idx_n;
         wtotal_r  <= wtotal_n;
         cfg_err_r <= cfg_err_n;
      end
   end

   assign o_wready  = wready_s;
   assign o_rvalid  = rvalid_s;
   assign o_rdata   = rvalid_s ? mem_rd_s[DWd-1:0] : {DWd{1'b0}};
   assign o_rzero   = rvalid_s ? mem_rd_s[DWd] : 1'b0;
   assign o_rlast   = rvalid_s && win_end_s;
   assign o_busy    = (state_r == RUN);
   assign o_done    = (state_r == DONE);
   assign o_cfg_err = cfg_err_r;

endmodule

// File: tb/tb_pe_ipad_ring.sv
// tb_pe_ipad_ring
// Directed bench for pe_ipad_ring (Depth=12, DWd=16). Expected read pixels are
// queued from the written stream when each job starts and popped on read fires.
module tb_pe_ipad_ring;

   localparam int DEPTH = 12;

   logic        clk = 1'b0;
   logic        rstn, clear, stall, start;
   logic [3:0]  conf_win, conf_stride;
   logic [9:0]  conf_nwin;
   logic [3:0]  conf_reps;
   logic        wvalid, wready, rvalid, rready;
   logic [15:0] wdata, rdata;
   logic        rzero, rlast, busy, done, cfg_err;

   int errors = 0;
   int checks = 0;
   int src[$];
   int exp_d[$];
   bit exp_l[$];

   always #5 clk = ~clk;

   pe_ipad_ring dut (
      .i_clk(clk), .i_rstn(rstn), .i_clear(clear), .i_stall(stall), .i_start(start),
      .i_conf_win(conf_win), .i_conf_stride(conf_stride), .i_conf_nwin(conf_nwin),
      .i_conf_reps(conf_reps),
      .i_wvalid(wvalid), .o_wready(wready), .i_wdata(wdata),
      .o_rvalid(rvalid), .i_rready(rready), .o_rdata(rdata),
      .o_rzero(rzero), .o_rlast(rlast), .o_busy(busy), .o_done(done), .o_cfg_err(cfg_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full job: src holds the pixel stream; the bench models count/k/rep to predict handshakes
   task automatic run_job(input int win, input int stride, input int nwin, input int reps,
                          input bit rnd, input int hold, input int stall_at);
      int limit, widx, cnt, k_m, rep_m, widx_m, dut_w, d;
      bit done_m, exp_wr, exp_rv, wf, rf, pop, stl, lst;
      limit = (nwin - 1) * stride + win;
      exp_d.delete();
      exp_l.delete();
      for (int w = 0; w < nwin; w++)
         for (int r = 0; r < reps; r++)
            for (int k = 0; k < win; k++) begin
               exp_d.push_back(src[w * stride + k]);
               exp_l.push_back(k == win - 1);
            end
      conf_win = 4'(win); conf_stride = 4'(stride);
      conf_nwin = 10'(nwin); conf_reps = 4'(reps);
      start = 1'b1; wvalid = 1'b0; rready = 1'b0; stall = 1'b0;
      @(negedge clk);
      check("start_no_err", 32'(cfg_err), 32'd0);
      step();
      start = 1'b0;
      widx = 0; cnt = 0; k_m = 0; rep_m = 0; widx_m = 0; dut_w = 0; done_m = 1'b0;
      for (int cyc = 0; cyc < 800 && !done_m; cyc++) begin
         stl    = (cyc >= stall_at) && (cyc < stall_at + 3);
         stall  = stl;
         wvalid = (widx < src.size()) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
         wdata  = (widx < src.size()) ? 16'(src[widx]) : 16'h0;
         rready = (cyc >= hold) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
         @(negedge clk);
         exp_wr = !stl && (cnt < DEPTH) && (widx < limit);
         exp_rv = !stl && (k_m < cnt);
         check("wready", 32'(wready), 32'(exp_wr));
         check("rvalid", 32'(rvalid), 32'(exp_rv));
         if (wready && wvalid) dut_w++;
         if (!rvalid) begin
            check("rdata_gated", 32'(rdata), 32'd0);
            check("rlast_gated", 32'(rlast), 32'd0);
         end
         if (hold > 0 && cyc == hold - 1) begin
            check("full_writes", 32'(dut_w), 32'(DEPTH));
            check("full_wready", 32'(wready), 32'd0);
         end
         wf = exp_wr && wvalid;
         rf = exp_rv && rready;
         if (rf) begin
            if (exp_d.size() == 0) begin
               check("extra_read", 32'(rdata), 32'hFFFF_FFFF);
            end else begin
               d = exp_d.pop_front();
               lst = exp_l.pop_front();
               check("rdata", 32'(rdata), 32'(d));
               check("rzero", 32'(rzero), 32'(d == 0));
               check("rlast", 32'(rlast), 32'(lst));
            end
         end
         pop = rf && (k_m == win - 1) && (rep_m == reps - 1);
         if (rf) begin
            if (k_m == win - 1) begin
               k_m = 0;
               if (rep_m == reps - 1) begin
                  rep_m = 0;
                  if (widx_m == nwin - 1) done_m = 1'b1;
                  widx_m++;
               end else rep_m++;
            end else k_m++;
         end
         cnt = cnt + (wf ? 1 : 0) - (pop ? stride : 0);
         if (wf) widx++;
         step();
      end
      wvalid = 1'b0; rready = 1'b0; stall = 1'b0;
      @(negedge clk);
      check("done", 32'(done), 32'd1);
      check("busy_after", 32'(busy), 32'd0);
      check("writes_accepted", 32'(dut_w), 32'(limit));
      check("reads_left", 32'(exp_d.size()), 32'd0);
   endtask

   initial begin
      int bad_cfg [6][4] = '{'{13,1,1,1}, '{0,1,1,1}, '{3,0,1,1},
                             '{3,4,1,1}, '{3,1,0,1}, '{3,1,1,0}};
      rstn = 1'b0; clear = 1'b0; stall = 1'b0; start = 1'b0;
      conf_win = 4'd0; conf_stride = 4'd0; conf_nwin = 10'd0; conf_reps = 4'd0;
      wvalid = 1'b0; wdata = 16'd0; rready = 1'b0;
      step(); step();
      @(negedge clk);
      check("rst_wready", 32'(wready), 32'd0);
      check("rst_rvalid", 32'(rvalid), 32'd0);
      check("rst_rdata", 32'(rdata), 32'd0);
      check("rst_rzero", 32'(rzero), 32'd0);
      check("rst_rlast", 32'(rlast), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_cfg_err", 32'(cfg_err), 32'd0);
      rstn = 1'b1;
      step();

      // Rejected configurations: one-cycle error pulse, no state change
      for (int i = 0; i < 6; i++) begin
         conf_win = 4'(bad_cfg[i][0]); conf_stride = 4'(bad_cfg[i][1]);
         conf_nwin = 10'(bad_cfg[i][2]); conf_reps = 4'(bad_cfg[i][3]);
         start = 1'b1;
         step();
         start = 1'b0;
         @(negedge clk);
         check("cfg_err_pulse", 32'(cfg_err), 32'd1);
         check("cfg_err_idle", 32'(busy), 32'd0);
         step();
         @(negedge clk);
         check("cfg_err_clear", 32'(cfg_err), 32'd0);
         check("cfg_err_not_done", 32'(done), 32'd0);
      end

      // Sliding window, overlapping stride
      src = '{1, 2, 3, 4, 5, 6};
      run_job(3, 1, 4, 1, 1'b0, 0, 10000);
      // Non-overlapping windows read twice each
      run_job(3, 3, 2, 2, 1'b0, 0, 10000);
      // Full ring back-pressure, then drain
      src.delete();
      for (int i = 1; i <= 24; i++) src.push_back(i);
      run_job(12, 12, 2, 1, 1'b0, 20, 10000);
      // Random handshakes with pointer wrap
      src.delete();
      for (int i = 1; i <= 15; i++) src.push_back(i);
      run_job(5, 2, 6, 1, 1'b1, 0, 10000);
      // Zero flag, with a stall in the middle
      src = '{7, 0, 9};
      run_job(3, 1, 1, 1, 1'b0, 0, 2);

      // Soft clear mid-run
      conf_win = 4'd3; conf_stride = 4'd1; conf_nwin = 10'd1; conf_reps = 4'd1;
      start = 1'b1;
      step();
      start = 1'b0; wvalid = 1'b1; wdata = 16'd5; rready = 1'b0;
      step(); step();
      @(negedge clk);
      check("clear_pre_busy", 32'(busy), 32'd1);
      clear = 1'b1;
      step();
      clear = 1'b0;
      @(negedge clk);
      check("clear_busy", 32'(busy), 32'd0);
      check("clear_done", 32'(done), 32'd0);
      check("clear_wready", 32'(wready), 32'd0);
      check("clear_rvalid", 32'(rvalid), 32'd0);
      check("clear_rdata", 32'(rdata), 32'd0);
      check("clear_rlast", 32'(rlast), 32'd0);
      wvalid = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
